// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// alu_cmd_sequencer : command FIFO + sequencer in front of the 8-bit ALU
// Rev 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmdValid,
  output logic                      cmdReady,
  input  logic [3:0]                cmdOp,
  input  logic [WIDTH-1:0]          cmdA,
  input  logic [WIDTH-1:0]          cmdB,
  input  logic                      cmdChain,
  output logic [WIDTH-1:0]          aluFirst,
  output logic [WIDTH-1:0]          aluSecond,
  output logic [3:0]                aluOp,
  input  logic [WIDTH-1:0]          aluResult,
  input  logic                      aluCarry,
  output logic                      resValid,
  input  logic                      resReady,
  output logic [WIDTH-1:0]          resData,
  output logic                      resCarry,
  output logic                      resDivZero,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 + 2 * WIDTH + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [EW-1:0]         fifo_q [DEPTH];
  logic [EW-1:0]         fifo_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      alu_first_q, alu_first_d;
  logic [WIDTH-1:0]      alu_second_q, alu_second_d;
  logic [3:0]            alu_op_q, alu_op_d;
  logic [WIDTH-1:0]      res_data_q, res_data_d;
  logic                  res_carry_q, res_carry_d;
  logic                  res_div_zero_q, res_div_zero_d;
  logic                  res_valid_q, res_valid_d;
  logic [WIDTH-1:0]      last_result_q, last_result_d;

  logic                  push;
  logic                  load;
  logic                  fifo_empty;
  logic                  div_zero;
  logic                  add_like;
  logic [EW-1:0]         head;

  assign cmdReady   = (count_q != CNT_FULL);
  assign aluFirst   = alu_first_q;
  assign aluSecond  = alu_second_q;
  assign aluOp      = alu_op_q;
  assign resValid   = res_valid_q;
  assign resData    = res_data_q;
  assign resCarry   = res_carry_q;
  assign resDivZero = res_div_zero_q;
  assign count      = count_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    fifo_d         = fifo_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    state_d        = state_q;
    alu_first_d    = alu_first_q;
    alu_second_d   = alu_second_q;
    alu_op_d       = alu_op_q;
    res_data_d     = res_data_q;
    res_carry_d    = res_carry_q;
    res_div_zero_d = res_div_zero_q;
    res_valid_d    = res_valid_q;
    last_result_d  = last_result_q;

    fifo_empty = (count_q == '0);
    push       = cmdValid && cmdReady;
    load       = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_HOLD) && resReady));
    head       = fifo_q[rd_ptr_q];
    div_zero   = (alu_op_q == 4'b0011) && (alu_second_q == '0);
    // The ALU falls back to an add for undefined codes, so carry is meaningful there too
    add_like   = (alu_op_q == 4'b0000) || (alu_op_q[3:2] == 2'b01) ||
                 (alu_op_q >= 4'b1011);

    if (push) begin
      fifo_d[wr_ptr_q] = {cmdOp, cmdA, cmdB, cmdChain};
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end

    if (load) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      alu_op_d     = head[EW-1 -: 4];
      alu_first_d  = head[0] ? last_result_q : head[2*WIDTH:WIDTH+1];
      alu_second_d = head[WIDTH:1];
    end

    case ({push, load})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (load) state_d = S_EXEC;
      end
      S_EXEC: begin
        res_valid_d    = 1'b1;
        res_div_zero_d = div_zero;
        res_data_d     = div_zero ? {WIDTH{1'b1}} : aluResult;
        res_carry_d    = !div_zero && add_like && aluCarry;
        last_result_d  = div_zero ? {WIDTH{1'b1}} : aluResult;
        state_d        = S_HOLD;
      end
      S_HOLD: begin
        if (resReady) begin
          res_valid_d = 1'b0;
          state_d     = load ? S_EXEC : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      fifo_q         <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      alu_first_q    <= '0;
      alu_second_q   <= '0;
      alu_op_q       <= '0;
      res_data_q     <= '0;
      res_carry_q    <= 1'b0;
      res_div_zero_q <= 1'b0;
      res_valid_q    <= 1'b0;
      last_result_q  <= '0;
    end else begin
      state_q        <= state_d;
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      alu_first_q    <= alu_first_d;
      alu_second_q   <= alu_second_d;
      alu_op_q       <= alu_op_d;
      res_data_q     <= res_data_d;
      res_carry_q    <= res_carry_d;
      res_div_zero_q <= res_div_zero_d;
      res_valid_q    <= res_valid_d;
      last_result_q  <= last_result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_sequencer : directed self-checking bench for alu_cmd_sequencer
// Rev 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmdValid, cmdReady, cmdChain;
  logic [3:0] cmdOp;
  logic [7:0] cmdA, cmdB;
  logic [7:0] aluFirst, aluSecond, aluResult;
  logic [3:0] aluOp;
  logic       aluCarry;
  logic       resValid, resReady, resCarry, resDivZero, busy;
  logic [7:0] resData;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_cmd_sequencer #(.DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdA(cmdA), .cmdB(cmdB), .cmdChain(cmdChain),
    .aluFirst(aluFirst), .aluSecond(aluSecond), .aluOp(aluOp),
    .aluResult(aluResult), .aluCarry(aluCarry),
    .resValid(resValid), .resReady(resReady), .resData(resData),
    .resCarry(resCarry), .resDivZero(resDivZero),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: carry always reflects the add path
  logic [8:0]  sum;
  logic [15:0] prod;
  always_comb begin
    sum      = {1'b0, aluFirst} + {1'b0, aluSecond};
    prod     = {8'd0, aluFirst} * {8'd0, aluSecond};
    aluCarry = sum[8];
    case (aluOp)
      4'b0001: aluResult = aluFirst - aluSecond;
      4'b0010: aluResult = prod[7:0];
      4'b0011: aluResult = (aluSecond == 8'd0) ? 8'h00 : aluFirst / aluSecond;
      4'b1000: aluResult = aluFirst & aluSecond;
      4'b1001: aluResult = aluFirst | aluSecond;
      4'b1010: aluResult = aluFirst ^ aluSecond;
      default: aluResult = sum[7:0];
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic ch);
    @(negedge clk);
    cmdValid = 1'b1; cmdOp = op; cmdA = a; cmdB = b; cmdChain = ch;
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [7:0] data, input logic carry,
                             input logic dz);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resValid && n < 20);
    check_eq({tag, "_valid"}, resValid, 1);
    check_eq({tag, "_data"}, resData, data);
    check_eq({tag, "_carry"}, resCarry, carry);
    check_eq({tag, "_dz"}, resDivZero, dz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int prev;
    reset = 1'b1; cmdValid = 1'b0; cmdOp = '0; cmdA = '0; cmdB = '0; cmdChain = 1'b0;
    resReady = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_valid", resValid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmdReady, 1);
    check_eq("rst_alu", {aluOp, aluFirst, aluSecond}, 0);
    check_eq("rst_res", {resData, resCarry, resDivZero}, 0);
    reset = 1'b0;
    resReady = 1'b1;

    // Exact latency: push at E0, load at E1, result after E2
    push_cmd(4'b0000, 8'd200, 8'd100, 1'b0);
    @(negedge clk);
    check_eq("lat_e0_count", count, 1);
    check_eq("lat_e0_valid", resValid, 0);
    @(negedge clk);
    check_eq("lat_e1_valid", resValid, 0);
    check_eq("lat_e1_alu", {aluOp, aluFirst, aluSecond}, {4'b0000, 8'd200, 8'd100});
    check_eq("lat_e1_count", count, 0);
    @(negedge clk);
    check_eq("lat_e2_valid", resValid, 1);
    check_eq("add_data", resData, 8'h2C);
    check_eq("add_carry", resCarry, 1);
    check_eq("add_dz", resDivZero, 0);
    @(negedge clk);
    check_eq("add_done_valid", resValid, 0);
    check_eq("add_done_busy", busy, 0);

    push_cmd(4'b0001, 8'd5, 8'd7, 1'b0);
    push_cmd(4'b1000, 8'hF0, 8'h3C, 1'b0);
    wait_result("sub", 8'hFE, 1'b0, 1'b0);
    wait_result("and", 8'h30, 1'b0, 1'b0);

    push_cmd(4'b1100, 8'h80, 8'h90, 1'b0);
    wait_result("undef", 8'h10, 1'b1, 1'b0);

    push_cmd(4'b0000, 8'd3, 8'd4, 1'b0);
    push_cmd(4'b0010, 8'h55, 8'd6, 1'b1);
    wait_result("chain1", 8'd7, 1'b0, 1'b0);
    wait_result("chain2", 8'd42, 1'b0, 1'b0);

    push_cmd(4'b0011, 8'd10, 8'd0, 1'b0);
    push_cmd(4'b0011, 8'd100, 8'd7, 1'b0);
    wait_result("div0", 8'hFF, 1'b0, 1'b1);
    wait_result("div7", 8'd14, 1'b0, 1'b0);

    // Backpressure: six back-to-back offers, five should fit
    @(negedge clk);
    resReady = 1'b0;
    accepted = 0;
    for (int i = 1; i <= 6; i++) begin
      cmdValid = 1'b1; cmdOp = 4'b0000; cmdA = 8'(i); cmdB = 8'd10; cmdChain = 1'b0;
      if (cmdReady) accepted++;
      @(negedge clk);
    end
    cmdValid = 1'b0;
    check_eq("bp_accepted", accepted, 5);
    check_eq("bp_count", count, 4);
    check_eq("bp_ready", cmdReady, 0);
    repeat (3) @(negedge clk);
    check_eq("bp_hold_valid", resValid, 1);
    check_eq("bp_hold_data", resData, 8'd11);
    resReady = 1'b1;
    prev = cyc;
    for (int k = 2; k <= 5; k++) begin
      wait_result($sformatf("drain%0d", k), 8'(10 + k), 1'b0, 1'b0);
      check_eq($sformatf("drain%0d_gap", k), cyc - prev, 2);
      prev = cyc;
    end
    @(negedge clk);
    check_eq("drain_idle", busy, 0);

    // Reset while holding a result with three commands queued
    resReady = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(4'b0000, 8'd1, 8'(i), 1'b0);
    @(negedge clk);
    check_eq("mid_count", count, 3);
    check_eq("mid_valid", resValid, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", resValid, 0);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_res", {resData, aluFirst}, 0);
    @(negedge clk);
    reset = 1'b0;
    resReady = 1'b1;
    push_cmd(4'b0000, 8'h77, 8'd9, 1'b1);
    wait_result("post_rst_chain", 8'd9, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command stage for the 8-bit combinational ALU. It buffers operand/opcode commands in a small FIFO, drives the ALU inputs from registers, captures the ALU result and carry one cycle later, and presents each result on a valid/ready output handshake. It also supports chaining a command onto the previous result, and substitutes a fixed result for divide-by-zero.

Parameters:
DEPTH, 4, command FIFO depth in entries; must be a power of 2 and at least 2.
WIDTH, 8, operand and result width; fixed at 8 to match the ALU.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-high
cmdValid  input  1  command present
cmdReady  output  1  FIFO can accept a command
cmdOp  input  4  ALU opcode
cmdA  input  8  first operand
cmdB  input  8  second operand
cmdChain  input  1  use the last result as the first operand instead of cmdA
aluFirst  output  8  registered drive to the ALU firstInput
aluSecond  output  8  registered drive to the ALU secondInput
aluOp  output  4  registered drive to the ALU operation
aluResult  input  8  ALU_Out
aluCarry  input  1  ALU CarryOut
resValid  output  1  result valid
resReady  input  1  consumer accepts the result
resData  output  8  captured result
resCarry  output  1  captured carry
resDivZero  output  1  result came from a divide-by-zero substitution
busy  output  1  high when state is not IDLE or the FIFO is non-empty
count  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is asynchronous and active-high:
  - FIFO empty, count=0, state=IDLE, lastResult=0.
  - aluFirst, aluSecond, aluOp, resData, resCarry, resDivZero and resValid all 0.
  - Pushes are ignored while reset is high.
- FIFO:
  - A push occurs on a clock edge where cmdValid && cmdReady; it stores {cmdOp, cmdA, cmdB, cmdChain}.
  - cmdReady = (count != DEPTH), combinational.
  - A pop occurs when the FSM loads the head entry.
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if the FIFO is non-empty at an edge, load the head into the ALU registers, pop it, and go to EXEC.
  - Load rule: aluFirst = cmdChain ? lastResult : cmdA; aluSecond = cmdB; aluOp = cmdOp.
  - EXEC: at the next edge, capture the result, set resValid=1 and go to HOLD. This edge also sets resDivZero and updates lastResult to the new resData.
  - HOLD: all res* outputs are held stable while resValid && !resReady.
  - HOLD exit: on an edge with resReady=1, clear resValid. If the FIFO is non-empty at that edge, load the next head in the same edge and go to EXEC; otherwise go to IDLE.
- Latency and throughput:
  - A command pushed into an empty, idle block at edge E0 is loaded at E1; resValid is asserted after E2.
  - Best-case throughput is one result per 2 cycles.
- Capture rules:
  - Divide-by-zero (aluOp==4'b0011 and aluSecond==0): resData=8'hFF, resCarry=0, resDivZero=1. The ALU output is ignored.
  - Otherwise resData = aluResult and resDivZero = 0.
  - resCarry = aluCarry only when aluOp is 0000 or any undefined code (0100–0111, 1011–1111), since the ALU computes an add for these; 0 for all other opcodes.
  - Undefined opcodes are forwarded to the ALU unchanged.
- Chaining: lastResult is always fully captured before the next load, because loads occur only after the HOLD handshake. A chained command therefore always sees the immediately preceding result. Chaining the first command after reset uses 0.
- Capacity:
  - The FIFO can be full while one command is in EXEC/HOLD, so DEPTH+1 commands are outstanding at most.
  - cmdReady low blocks pushes; cmdValid may stay high without effect.
- Reset mid-operation, in EXEC or HOLD: the in-flight command and all queued commands are discarded, and all outputs return to reset values immediately.

Test Plan:
- ADD A=200 B=100, resReady=1 → resValid 2 cycles after acceptance, resData=0x2C, resCarry=1, resDivZero=0.
- SUB A=5 B=7 → resData=0xFE, resCarry=0; then AND A=0xF0 B=0x3C → resData=0x30, resCarry=0.
- Chain: ADD 3+4, then MUL B=6 with cmdChain=1 (cmdA=0x55) → first result 7, second result 42 (0x2A).
- DIV A=10 B=0 → resData=0xFF, resDivZero=1; next command DIV 100/7 → resData=14, resDivZero=0.
- Backpressure: resReady=0 and 6 back-to-back commands with DEPTH=4 → exactly 5 accepted, cmdReady low with count=4. Releasing resReady drains results in order, one per 2 cycles.
- Assert reset while in HOLD with count=3 → resValid=0, count=0, busy=0 immediately. A post-reset chained ADD B=9 yields resData=9.
